// File: rtl/axis_fifo_pkg.sv
// Sizing helpers shared by the synchronous AXI-Stream FIFO family.
package axis_fifo_pkg;

    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

    function automatic int fifo_aw(input int depth);
        int aw;
        aw = $clog2(depth - 32'sd1);
        return (aw < 32'sd1) ? 32'sd1 : aw;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream channel: valid/ready handshake carrying tdata.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ram_async.sv
// Register-file RAM: synchronous write, asynchronous (combinational) read.
module ram_async #(
    parameter int DW    = 8,
    parameter int AW    = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/axis_sync_fifo_lvl.sv
// Synchronous AXI-Stream FIFO of any DEPTH >= 2 with a registered output stage,
// occupancy level, programmable almost-full/almost-empty flags and a flush input.
module axis_sync_fifo_lvl
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_if.m                         axis_mif,
    axis_if.s                         axis_sif,
    input  logic                      invalidate,
    output logic [fifo_cw(DEPTH)-1:0] level,
    output logic                      almost_full,
    output logic                      almost_empty
);
    localparam int CW        = fifo_cw(DEPTH);
    localparam int AW        = fifo_aw(DEPTH);
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int DW        = $bits(axis_mif.tdata);
    localparam int SW        = $bits(axis_sif.tdata);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 2);

    if (DEPTH < 2) begin : g_chk_depth
        $fatal(1, "axis_sync_fifo_lvl: DEPTH must be >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
        $fatal(1, "axis_sync_fifo_lvl: AFULL_THRESH out of range 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_chk_aempty
        $fatal(1, "axis_sync_fifo_lvl: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (DW != SW) begin : g_chk_width
        $fatal(1, "axis_sync_fifo_lvl: TDATA_WIDTH of axis_mif and axis_sif differ");
    end

    // RAM holds DEPTH-1 entries, so the pointers wrap at DEPTH-2 rather than at 2^AW.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = '0;
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    logic          tvalid_r, tvalid_d;
    logic [DW-1:0] tdata_r,  tdata_d;
    logic          tready_r, tready_d;
    logic [CW-1:0] count_r,  count_d;
    logic [AW-1:0] wptr_r,   wptr_d;
    logic [AW-1:0] rptr_r,   rptr_d;

    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] ram_cnt_s;
    logic          ram_empty_s;
    logic          to_out_s;
    logic          ram_we_s;
    logic [DW-1:0] ram_rdata_s;

    assign push_s      = axis_sif.tvalid && tready_r;
    assign pop_s       = tvalid_r && axis_mif.tready;
    assign ram_cnt_s   = count_r - CW'(tvalid_r);
    assign ram_empty_s = (ram_cnt_s == '0);
    // Fall-through only when nothing older is queued in the RAM.
    assign to_out_s    = push_s && (!tvalid_r || pop_s) && ram_empty_s;
    assign ram_we_s    = push_s && !to_out_s && !invalidate && !rst;

    ram_async #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wptr_r),
        .wdata (axis_sif.tdata),
        .raddr (rptr_r),
        .rdata (ram_rdata_s)
    );

    // Next-state for occupancy, pointers and the output register
    always_comb begin
        count_d  = count_r;
        wptr_d   = wptr_r;
        rptr_d   = rptr_r;
        tvalid_d = tvalid_r;
        tdata_d  = tdata_r;
        if (invalidate) begin
            count_d  = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            tvalid_d = 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_r + CW'(1);
                2'b01:   count_d = count_r - CW'(1);
                default: count_d = count_r;
            endcase
            if (ram_we_s) begin
                wptr_d = ptr_inc(wptr_r);
            end else begin
                wptr_d = wptr_r;
            end
            if (pop_s) begin
                if (!ram_empty_s) begin
                    tvalid_d = 1'b1;
                    tdata_d  = ram_rdata_s;
                    rptr_d   = ptr_inc(rptr_r);
                end else if (push_s) begin
                    tvalid_d = 1'b1;
                    tdata_d  = axis_sif.tdata;
                end else begin
                    tvalid_d = 1'b0;
                end
            end else if (to_out_s) begin
                tvalid_d = 1'b1;
                tdata_d  = axis_sif.tdata;
            end else begin
                tvalid_d = tvalid_r;
            end
        end
        tready_d = (count_d < DEPTH_C);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            tready_r <= 1'b0;
            count_r  <= '0;
            wptr_r   <= '0;
            rptr_r   <= '0;
        end else begin
            tvalid_r <= tvalid_d;
            tdata_r  <= tdata_d;
            tready_r <= tready_d;
            count_r  <= count_d;
            wptr_r   <= wptr_d;
            rptr_r   <= rptr_d;
        end
    end

    assign axis_mif.tvalid = tvalid_r;
    assign axis_mif.tdata  = tdata_r;
    assign axis_sif.tready = tready_r;

    assign level        = count_r;
    assign almost_full  = (count_r >= AFULL_C);
    assign almost_empty = (count_r <= AEMPTY_C);
endmodule

// File: tb/tb_axis_sync_fifo_lvl.sv
// Directed and scoreboard-checked bench for axis_sync_fifo_lvl at several depths.
module tb_axis_sync_fifo_lvl;
    localparam int NI = 6;

    function automatic int dep(input int i);
        case (i)
            0:       return 6;
            1:       return 5;
            2:       return 3;
            3:       return 2;
            4:       return 4;
            default: return 7;
        endcase
    endfunction

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NI-1:0]        s_valid, m_ready, inv;
    logic [NI-1:0]        s_ready, m_valid, af, ae;
    logic [NI-1:0][7:0]   s_data, m_data;
    logic [NI-1:0][3:0]   lvl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = dep(g);
        logic [$clog2(D+1)-1:0] lvl_s;
        axis_if #(.TDATA_WIDTH(8)) sif ();
        axis_if #(.TDATA_WIDTH(8)) mif ();

        assign sif.tvalid  = s_valid[g];
        assign sif.tdata   = s_data[g];
        assign mif.tready  = m_ready[g];
        assign s_ready[g]  = sif.tready;
        assign m_valid[g]  = mif.tvalid;
        assign m_data[g]   = mif.tdata;
        assign lvl[g]      = 4'(lvl_s);

        axis_sync_fifo_lvl #(
            .DEPTH         (D),
            .AFULL_THRESH  (D - 1),
            .AEMPTY_THRESH (1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .axis_mif     (mif),
            .axis_sif     (sif),
            .invalidate   (inv[g]),
            .level        (lvl_s),
            .almost_full  (af[g]),
            .almost_empty (ae[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random traffic with rare flushes against a queue reference model.
    task automatic soak(input int idx, input int d, input int cycles);
        logic [7:0] q[$];
        logic       pu, po;
        for (int c = 0; c < cycles; c++) begin
            s_valid[idx] = ($urandom_range(0, 3) != 0);
            s_data[idx]  = 8'($urandom);
            m_ready[idx] = ($urandom_range(0, 2) != 0);
            inv[idx]     = ($urandom_range(0, 39) == 0);
            pu = s_valid[idx] && s_ready[idx];
            po = m_valid[idx] && m_ready[idx];
            check("soak_valid", 32'(m_valid[idx]), 32'(q.size() != 0));
            if (po && (q.size() != 0)) begin
                check("soak_data", 32'(m_data[idx]), 32'(q[0]));
            end
            if (inv[idx]) begin
                q.delete();
            end else begin
                if (po && (q.size() != 0)) void'(q.pop_front());
                if (pu) q.push_back(s_data[idx]);
            end
            step();
            check("soak_level", 32'(lvl[idx]), 32'(q.size()));
            check("soak_tready", 32'(s_ready[idx]), 32'(q.size() < d));
            check("soak_flags", 32'({af[idx], ae[idx]}),
                  32'({q.size() >= (d - 1), q.size() <= 1}));
        end
        s_valid[idx] = 1'b0;
        m_ready[idx] = 1'b0;
        inv[idx]     = 1'b0;
    endtask

    initial begin
        int   sent, rcv, cnt;
        logic pu, po;

        rst     = 1'b1;
        s_valid = '0;
        m_ready = '0;
        inv     = '0;
        s_data  = '0;

        // Reset and first cycles after release
        step();
        step();
        check("rst_tready", 32'(s_ready[0]), 32'd0);
        check("rst_tvalid", 32'(m_valid[0]), 32'd0);
        check("rst_tdata", 32'(m_data[0]), 32'd0);
        step();
        rst = 1'b0;
        check("rel0_tready", 32'(s_ready[0]), 32'd0);
        check("rel0_level", 32'(lvl[0]), 32'd0);
        check("rel0_aempty", 32'(ae[0]), 32'd1);
        check("rel0_afull", 32'(af[0]), 32'd0);
        step();
        for (int i = 0; i < NI; i++) begin
            check("rel1_tready", 32'(s_ready[i]), 32'd1);
            check("rel1_tvalid", 32'(m_valid[i]), 32'd0);
        end

        // Fill DEPTH=6 with the output stalled, then drain
        for (int i = 1; i <= 6; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 8'(i);
            step();
            check("fill_level", 32'(lvl[0]), 32'(i));
            check("fill_afull", 32'(af[0]), 32'(i >= 5));
            check("fill_tready", 32'(s_ready[0]), 32'(i < 6));
            check("fill_head", 32'(m_data[0]), 32'h01);
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            check("drain_valid", 32'(m_valid[0]), 32'd1);
            check("drain_data", 32'(m_data[0]), 32'(i));
            step();
            check("drain_level", 32'(lvl[0]), 32'(6 - i));
            check("drain_aempty", 32'(ae[0]), 32'((6 - i) <= 1));
            if (i == 1) check("drain_tready", 32'(s_ready[0]), 32'd1);
        end
        m_ready[0] = 1'b0;
        check("drain_empty", 32'(m_valid[0]), 32'd0);

        // Streaming wrap, DEPTH=5, ready pattern 1,1,0
        sent = 0;
        rcv  = 0;
        cnt  = 0;
        for (int c = 0; (c < 200) && (rcv < 40); c++) begin
            s_valid[1] = (sent < 40);
            s_data[1]  = 8'(sent);
            m_ready[1] = ((c % 3) != 2);
            pu = s_valid[1] && s_ready[1];
            po = m_valid[1] && m_ready[1];
            if (po) begin
                check("wrap_data", 32'(m_data[1]), 32'(rcv));
                rcv++;
            end
            if (pu) sent++;
            cnt = cnt + (pu ? 1 : 0) - (po ? 1 : 0);
            step();
            check("wrap_level", 32'(lvl[1]), 32'(cnt));
            check("wrap_max", 32'(lvl[1] <= 4'd5), 32'd1);
        end
        s_valid[1] = 1'b0;
        m_ready[1] = 1'b0;
        check("wrap_count", 32'(rcv), 32'd40);

        // DEPTH=3 full: pop while D is offered against a low tready
        for (int i = 0; i < 3; i++) begin
            s_valid[2] = 1'b1;
            s_data[2]  = 8'hA1 + 8'(i * 17);
            step();
        end
        check("full_level", 32'(lvl[2]), 32'd3);
        check("full_tready", 32'(s_ready[2]), 32'd0);
        s_data[2]  = 8'hD4;
        m_ready[2] = 1'b1;
        check("full_head", 32'(m_data[2]), 32'hA1);
        step();
        check("full_pop_level", 32'(lvl[2]), 32'd2);
        check("full_pop_tready", 32'(s_ready[2]), 32'd1);
        m_ready[2] = 1'b0;
        step();
        s_valid[2] = 1'b0;
        check("full_d_level", 32'(lvl[2]), 32'd3);
        m_ready[2] = 1'b1;
        check("full_order_b", 32'(m_data[2]), 32'hB2);
        step();
        check("full_order_c", 32'(m_data[2]), 32'hC3);
        step();
        check("full_order_d", 32'(m_data[2]), 32'hD4);
        step();
        m_ready[2] = 1'b0;
        check("full_end_level", 32'(lvl[2]), 32'd0);

        // Invalidate at level 4 with concurrent push of 0xAA and pop
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 8'h11 + 8'(i);
            step();
        end
        check("inv_pre_level", 32'(lvl[0]), 32'd4);
        s_data[0]  = 8'hAA;
        m_ready[0] = 1'b1;
        inv[0]     = 1'b1;
        check("inv_head", 32'(m_data[0]), 32'h11);
        step();
        inv[0]     = 1'b0;
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b0;
        check("inv_level", 32'(lvl[0]), 32'd0);
        check("inv_tvalid", 32'(m_valid[0]), 32'd0);
        check("inv_tready", 32'(s_ready[0]), 32'd1);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h55;
        step();
        s_valid[0] = 1'b0;
        check("inv_post_valid", 32'(m_valid[0]), 32'd1);
        check("inv_post_data", 32'(m_data[0]), 32'h55);
        m_ready[0] = 1'b1;
        step();
        m_ready[0] = 1'b0;
        check("inv_post_empty", 32'(m_valid[0]), 32'd0);
        check("inv_post_level", 32'(lvl[0]), 32'd0);

        // Random soak at DEPTH 2, 4 and 7
        soak(3, 2, 400);
        soak(4, 4, 400);
        soak(5, 7, 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
